// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_tx
//  Description : Drains a 16-bit synchronous FIFO one word at a time and sends
//                each word as two 8N1 UART frames. The low byte goes first, and
//                each byte is sent LSB first. A new FIFO read is issued only
//                after the previous word has been completely shifted out.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
  parameter int DIV = 87            // clock cycles per serial bit, 2..65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic        fifo_valid,
  input  logic [15:0] fifo_dout,
  output logic        fifo_rd,
  output logic        txd,
  output logic        busy,
  output logic        drop
);

  localparam int                    c_BAUD_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_BAUD_W-1:0]   c_BAUD_LAST = c_BAUD_W'(DIV - 1);
  localparam logic [c_BAUD_W-1:0]   c_BAUD_ONE  = c_BAUD_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  state_t              r_state;
  logic [c_BAUD_W-1:0] r_baud;
  logic [2:0]          r_bit;
  logic                r_idx;
  logic [15:0]         r_hold;
  logic                r_fifo_rd;
  logic                r_txd;
  logic                r_busy;
  logic                r_drop;

  logic [7:0]          w_byte;
  logic [2:0]          w_bit_nxt;
  logic                w_baud_end;

  // Byte currently on the line, next bit position, and end of the bit period
  always_comb begin
    w_byte     = r_idx ? r_hold[15:8] : r_hold[7:0];
    w_bit_nxt  = r_bit + 3'd1;
    w_baud_end = (r_baud == c_BAUD_LAST);
  end

  // Word sequencer: all outputs are registered, so TXD and the pulses change
  // only on the edge where the state or bit changes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit     <= 3'd0;
      r_idx     <= 1'b0;
      r_hold    <= 16'h0000;
      r_fifo_rd <= 1'b0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_fifo_rd <= 1'b0;
      r_drop    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // ENABLE and FIFO_EMPTY only matter here; a word in flight always completes
          if (enable && !fifo_empty) begin
            r_state   <= S_READ;
            r_fifo_rd <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        S_READ: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (fifo_valid) begin
            r_hold  <= fifo_dout;
            r_idx   <= 1'b0;
            r_baud  <= '0;
            r_txd   <= 1'b0;
            r_state <= S_START;
          end else begin
            // Read was issued but the FIFO returned nothing (underflow)
            r_drop  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_txd   <= w_byte[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + c_BAUD_ONE;
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_bit   <= 3'd0;
              r_txd   <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit <= w_bit_nxt;
              r_txd <= w_byte[w_bit_nxt];
            end
          end else begin
            r_baud <= r_baud + c_BAUD_ONE;
          end
        end
        S_STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (!r_idx) begin
              // High byte follows immediately with no idle bit
              r_idx   <= 1'b1;
              r_txd   <= 1'b0;
              r_state <= S_START;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + c_BAUD_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_baud  <= '0;
          r_bit   <= 3'd0;
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd = r_fifo_rd;
  assign txd     = r_txd;
  assign busy    = r_busy;
  assign drop    = r_drop;

endmodule
`default_nettype wire

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream drain stage for the 16-bit synchronous FIFO. Pops one word at a time through the FIFO read port and transmits it on a serial line as two 8N1 UART frames: low byte first, each byte LSB first. It paces FIFO reads so that a new word is requested only after the previous word has been fully shifted out.

## Interface
- DIV, default 87 — clock cycles per serial bit (10 MHz / 115200); legal range 2..65535.
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  asynchronous, active-low reset.
- ENABLE  input  1  when 1, the block may start new words; when 0, no new FIFO reads are issued.
- FIFO_EMPTY  input  1  FIFO EMPTY flag.
- FIFO_VALID  input  1  FIFO VALID: FIFO_DOUT holds the popped word this cycle.
- FIFO_DOUT  input  16  FIFO read data.
- FIFO_RD  output  1  one-cycle read request to the FIFO RD input.
- TXD  output  1  serial line; idle high.
- BUSY  output  1  1 whenever state is not IDLE.
- DROP  output  1  one-cycle pulse when a read is issued but no VALID returns.

## Operation
- States: IDLE, READ, WAIT, START, DATA, STOP. A 1-bit byte index selects the low or high byte.
- Counters:
  - Baud counter: 0..DIV-1, width ceil(log2(DIV)).
  - Bit counter: 0..7.
- IDLE: if ENABLE=1 and FIFO_EMPTY=0, go to READ; otherwise stay in IDLE.
- READ: FIFO_RD=1 (Moore decode of this state only). Always go to WAIT next.
- WAIT:
  - If FIFO_VALID=1, latch FIFO_DOUT into a 16-bit holding register, set byte index to 0, and go to START.
  - Otherwise pulse DROP and return to IDLE. An UNDER condition lands here.
- START: TXD=0 for DIV cycles, then go to DATA with bit counter 0.
- DATA: TXD = selected byte[bit counter], each bit for DIV cycles. After bit 7, go to STOP.
- STOP: TXD=1 for DIV cycles, then:
  - byte index 0: set index to 1 and go to START, with no extra idle cycle;
  - byte index 1: go to IDLE.
- TXD is registered: it changes only on the edge where the state or bit changes.
- ENABLE dropping mid-word does not abort the word; the current word completes.
- ENABLE is checked only in IDLE.
- The FIFO_RD pulse is always exactly 1 cycle. The block never issues two reads for one word.

## Timing
- Reset (RST=0, asynchronous) forces:
  - state IDLE, all counters 0, holding register 0;
  - FIFO_RD=0, TXD=1, BUSY=0, DROP=0.
- Reset takes effect immediately, including mid-frame. TXD returns high without completing the frame.
- After RST is released, the first possible transition is at the first CLK edge.
- Edge e0 (IDLE, FIFO_EMPTY=0, ENABLE=1): state becomes READ, so FIFO_RD is high during cycle e0..e1.
- The FIFO samples RD at e1 and presents VALID/DOUT during e1..e2.
- The block samples FIFO_VALID at e2, and TXD falls after e2 (start bit).
- Line time per word: 20*DIV cycles (2 × 10 bits).
- Idle gap between consecutive words with FIFO non-empty: exactly 3 cycles of TXD=1 (IDLE, READ, WAIT).
- Word throughput: one word per 20*DIV+3 cycles.
- BUSY goes high at e0 and low on the edge that leaves the high-byte STOP state.
- A FIFO_EMPTY change during a frame is ignored.
- ENABLE and FIFO_EMPTY are sampled only in IDLE.
- The baud counter reloads to 0 on every bit boundary, so there is no cumulative drift.

## Test plan
- Reset: hold RST=0 for 3 cycles with FIFO_EMPTY=0 → TXD=1, FIFO_RD=0, BUSY=0, DROP=0 throughout; no RD pulse in the first cycle after release.
- Single word: DIV=4, push 16'hA55A, ENABLE=1 → exactly one FIFO_RD pulse. TXD then carries, 4 cycles per bit:
  - bits 0,0,1,0,1,1,0,1,0,1 (byte 5A);
  - then bits 0,1,0,1,0,0,1,0,1,1 (byte A5);
  - 80 line cycles, then BUSY=0.
- Back-to-back: DIV=4, push 16'h0001 and 16'hFFFF → two RD pulses 83 cycles apart. TXD high for exactly 3 cycles between the two words. Both words decode correctly.
- Missing VALID: force FIFO_EMPTY=0 with the FIFO holding FIFO_VALID=0 → RD pulse, then a DROP pulse 1 cycle later, TXD stays 1, state back in IDLE.
- ENABLE gating: ENABLE=0 with 4 words queued → no FIFO_RD for 100 cycles. Raise ENABLE → reads resume. Drop ENABLE mid-frame → the current word finishes and no further RD is issued.
- Reset mid-frame: DIV=4, assert RST=0 during DATA bit 3 → TXD=1 and BUSY=0 at once. After release, the next queued word is transmitted from its start bit.
